// File: rtl/or16_arbiter.sv
// -----------------------------------------------------------------------------
// or16_arbiter
//
// Purpose:
//   Shares one 16-bit OR datapath between NREQ requesters. An idle arbiter
//   picks one pending requester, pulses its grant for one cycle and captures
//   that requester's two operands. One cycle later it registers
//   operand1 | operand0 as the result. The result is then held until the
//   consumer accepts it. Each transaction takes at least 3 cycles:
//   IDLE -> EXEC -> HOLD -> IDLE.
//
// Compile-time option:
//   OR16_ARB_RR_EN  defined   : round-robin arbitration with a rotating pointer
//                   undefined : fixed priority, the lowest index wins
//
// Parameters:
//   NREQ       number of requesters (2..8)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous active-high reset
//   req        per-requester request level
//   req_i1     operand 1 per requester, requester i at [16i+15:16i]
//   req_i0     operand 0 per requester, same packing
//   gnt        registered one-hot grant pulse (one cycle)
//   out_valid  result available
//   out_data   i1 | i0 of the granted requester
//   out_id     index of the requester that owns out_data
//   out_ready  consumer accepts when out_valid && out_ready at a rising edge
//   busy       high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module or16_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*16-1:0]   req_i1,
  input  logic [NREQ*16-1:0]   req_i0,
  output logic [NREQ-1:0]      gnt,
  output logic                 out_valid,
  output logic [15:0]          out_data,
  output logic [2:0]           out_id,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_data_q, out_data_d;
  logic [2:0]      out_id_q, out_id_d;
  logic [15:0]     op1_q, op1_d;
  logic [15:0]     op0_q, op0_d;

  // Pad the request vector and the operand lanes to 8 entries. A 3-bit
  // winner index can then select from them for every legal NREQ.
  logic [7:0]  req_ext;
  logic [15:0] i1_lane [8];
  logic [15:0] i0_lane [8];

  assign req_ext = 8'(req);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < NREQ) begin : g_used
        assign i1_lane[gi] = req_i1[16*gi +: 16];
        assign i0_lane[gi] = req_i0[16*gi +: 16];
      end else begin : g_pad
        assign i1_lane[gi] = 16'h0000;
        assign i0_lane[gi] = 16'h0000;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  logic [2:0] win_idx;
  logic       win_found;

`ifdef OR16_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cand;

  // Search starts at the pointer and wraps at NREQ-1 back to 0.
  always_comb begin
    win_idx   = 3'd0;
    win_found = 1'b0;
    cand      = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      if (!win_found && req_ext[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  // The pointer moves only when a grant is actually issued.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && win_found) begin
      ptr_d = (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: scan downward so that the lowest set index is the
  // last one written.
  always_comb begin
    win_idx   = 3'd0;
    win_found = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_idx = 3'(k);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State machine: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    op1_d       = op1_q;
    op0_d       = op0_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          for (int k = 0; k < NREQ; k++) begin
            gnt_d[k] = (win_idx == 3'(k));
          end
          op1_d    = i1_lane[win_idx];
          op0_d    = i0_lane[win_idx];
          out_id_d = win_idx;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        out_data_d  = op1_q | op0_q;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        // out_valid_q is already high in this state. An out_ready that
        // coincides with entering HOLD therefore never counts as acceptance.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_id_q    <= 3'd0;
      op1_q       <= 16'h0000;
      op0_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      op1_q       <= op1_d;
      op0_q       <= op0_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_or16_arbiter.sv
// -----------------------------------------------------------------------------
// tb_or16_arbiter
//
// Directed testbench for or16_arbiter with NREQ = 4. It runs the following
// directed cases, each with hand-computed expected values:
//   - reset state
//   - single transaction
//   - contention
//   - pointer wrap
//   - operand patterns
//   - backpressure
//   - reset while holding a result
//
// Expected grant orders follow the arbitration policy selected by
// OR16_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_or16_arbiter;

  localparam int NREQ = 4;

  logic             clk;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [NREQ*16-1:0] req_i1;
  logic [NREQ*16-1:0] req_i0;
  logic [NREQ-1:0]  gnt;
  logic             out_valid;
  logic [15:0]      out_data;
  logic [2:0]       out_id;
  logic             out_ready;
  logic             busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  or16_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_i1    (req_i1),
    .req_i0    (req_i0),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every lane gets junk operands; only lane idx gets the values of interest.
  // Junk ORs to 16'h1AB4, so a wrongly selected lane shows up in out_data.
  task automatic set_ops(input int idx, input logic [15:0] a1, input logic [15:0] a0);
    for (int k = 0; k < NREQ; k++) begin
      req_i1[16*k +: 16] = (k == idx) ? a1 : 16'h1234;
      req_i0[16*k +: 16] = (k == idx) ? a0 : 16'h0880;
    end
  endtask

  // Overwrites every lane after the capture edge. Any result that still
  // depends on live operands then reads 16'h5A5A.
  task automatic scramble_ops();
    for (int k = 0; k < NREQ; k++) begin
      req_i1[16*k +: 16] = 16'h5A00;
      req_i0[16*k +: 16] = 16'h005A;
    end
  endtask

  // One full transaction with out_ready held high.
  task automatic txn(input string tag, input logic [3:0] r, input int exp_id,
                     input logic [15:0] a1, input logic [15:0] a0,
                     input logic [15:0] exp_d);
    logic [3:0] oh;
    oh = 4'(1 << exp_id);
    set_ops(exp_id, a1, a0);
    req       = r;
    out_ready = 1'b1;
    tick();
    check({tag, "_gnt"},       32'(gnt),       32'(oh));
    check({tag, "_busy_exec"}, 32'(busy),      32'd1);
    check({tag, "_vld_exec"},  32'(out_valid), 32'd0);
    // The requester drops its request once it sees the grant. The operands
    // change while the arbiter is in EXEC.
    req = r & ~oh;
    scramble_ops();
    tick();
    check({tag, "_vld_hold"},  32'(out_valid), 32'd1);
    check({tag, "_data"},      32'(out_data),  32'(exp_d));
    check({tag, "_id"},        32'(out_id),    32'(exp_id));
    check({tag, "_gnt_hold"},  32'(gnt),       32'd0);
    tick();
    check({tag, "_vld_acc"},   32'(out_valid), 32'd0);
    check({tag, "_busy_acc"},  32'(busy),      32'd0);
    check({tag, "_data_kept"}, 32'(out_data),  32'(exp_d));
    check({tag, "_id_kept"},   32'(out_id),    32'(exp_id));
  endtask

  int         cont_exp [4];
  int         wrap2_id;
  int         bp_id;
  int         bp_next_id;
  logic [3:0] bp_next_req;

  initial begin
`ifdef OR16_ARB_RR_EN
    cont_exp    = '{1, 3, 1, 3};
    wrap2_id    = 3;
    bp_id       = 3;
    bp_next_id  = 0;
    bp_next_req = 4'b0111;
`else
    cont_exp    = '{1, 1, 1, 1};
    wrap2_id    = 0;
    bp_id       = 0;
    bp_next_id  = 1;
    bp_next_req = 4'b1110;
`endif
    reset     = 1'b1;
    req       = '0;
    req_i1    = '0;
    req_i0    = '0;
    out_ready = 1'b1;

    // Reset state, checked before any clock edge.
    #2;
    check("rst_gnt",  32'(gnt),       32'd0);
    check("rst_vld",  32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data),  32'd0);
    check("rst_id",   32'(out_id),    32'd0);
    check("rst_busy", 32'(busy),      32'd0);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single requester.
    txn("single", 4'b0001, 0, 16'hF000, 16'h000F, 16'hF00F);

    // Contention between requesters 1 and 3, re-raised every transaction.
    for (int n = 0; n < 4; n++) begin
      txn($sformatf("cont%0d", n), 4'b1010, cont_exp[n], 16'h8001, 16'h0100, 16'h8101);
    end

    // Wrap: after a grant to 3 (or 1 with fixed priority), req 1001 grants 0.
    txn("wrap", 4'b1001, 0, 16'h0F0F, 16'h3030, 16'h3F3F);
    // The pointer is now 1: round-robin goes to 3, fixed priority stays at 0.
    txn("wrap2", 4'b1001, wrap2_id, 16'h4400, 16'h0022, 16'h4422);

    // Operand patterns.
    txn("pat_ff", 4'b0010, 1, 16'hAAAA, 16'h5555, 16'hFFFF);
    txn("pat_00", 4'b0100, 2, 16'h0000, 16'h0000, 16'h0000);

    // Backpressure with all requests held high.
    set_ops(bp_id, 16'hC3C3, 16'h0C30);
    req       = 4'b1111;
    out_ready = 1'b0;
    tick();
    check("bp_gnt", 32'(gnt), 32'(4'(1 << bp_id)));
    scramble_ops();
    tick();
    check("bp_vld",  32'(out_valid), 32'd1);
    check("bp_data", 32'(out_data),  32'h0000CFF3);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_wait%0d_vld", c),  32'(out_valid), 32'd1);
      check($sformatf("bp_wait%0d_data", c), 32'(out_data),  32'h0000CFF3);
      check($sformatf("bp_wait%0d_id", c),   32'(out_id),    32'(bp_id));
      check($sformatf("bp_wait%0d_gnt", c),  32'(gnt),       32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_acc_vld",  32'(out_valid), 32'd0);
    check("bp_acc_gnt",  32'(gnt),       32'd0);
    check("bp_acc_busy", 32'(busy),      32'd0);
    txn("bp_next", bp_next_req, bp_next_id, 16'h1000, 16'h0001, 16'h1001);

    // Asynchronous reset while a result is held.
    set_ops(2, 16'h00FF, 16'h0F00);
    req       = 4'b0100;
    out_ready = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    check("rhold_vld", 32'(out_valid), 32'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rhold_gnt",  32'(gnt),       32'd0);
    check("rhold_vld0", 32'(out_valid), 32'd0);
    check("rhold_data", 32'(out_data),  32'd0);
    check("rhold_id",   32'(out_id),    32'd0);
    check("rhold_busy", 32'(busy),      32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst%0d_vld", c), 32'(out_valid), 32'd0);
      check($sformatf("post_rst%0d_gnt", c), 32'(gnt),       32'd0);
    end
    // The pointer is back at 0, so both policies grant 0.
    txn("post_rst", 4'b1001, 0, 16'h0202, 16'h2020, 16'h2222);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
